// File: rtl/mib_cmd_slave.sv
// MIB bus slave: collects address/data phases from the MIB master and replays each one as a
// single command-bus transaction, returning the write ack or two read-data halves.
module mib_cmd_slave #(
  parameter logic [3:0]  P_MIB_MSN              = 4'h0,
  parameter int unsigned P_CMD_ACK_TIMEOUT_CLKS = 16
) (
  input  logic        i_sysclk,
  input  logic        i_srst,
  input  logic        i_mib_start,
  input  logic        i_mib_rd_wr_n,
  input  logic [15:0] i_mib_ad,
  output logic [15:0] o_mib_ad,
  output logic        o_mib_ad_oe,
  output logic        o_mib_slave_ack,
  output logic        o_cmd_sel,
  output logic        o_cmd_rd_wr_n,
  output logic [23:0] o_cmd_byte_addr,
  output logic [31:0] o_cmd_wdata,
  input  logic        i_cmd_ack,
  input  logic [31:0] i_cmd_rdata,
  output logic        o_cmd_timeout
);

  typedef enum logic [2:0] {
    StIdle,
    StAddr2,
    StWdata1,
    StWdata2,
    StCmdWait,
    StRdHi,
    StRdLo
  } state_e;

  // Last wait-counter value (counter is 0 in the sel cycle) on which an ack is still accepted.
  localparam logic [7:0] TimeoutLast = 8'(P_CMD_ACK_TIMEOUT_CLKS - 1);

  state_e      state_q;
  logic [7:0]  wait_cnt_q;
  logic [15:0] rdata_lo_q;
  logic [15:0] mib_ad_q;
  logic        mib_ad_oe_q;
  logic        mib_ack_q;
  logic        cmd_sel_q;
  logic        cmd_rd_wr_n_q;
  logic [23:0] cmd_addr_q;
  logic [31:0] cmd_wdata_q;
  logic        cmd_timeout_q;

  always_ff @(posedge i_sysclk) begin
    if (i_srst) begin
      state_q       <= StIdle;
      wait_cnt_q    <= '0;
      rdata_lo_q    <= '0;
      mib_ad_q      <= '0;
      mib_ad_oe_q   <= 1'b0;
      mib_ack_q     <= 1'b0;
      cmd_sel_q     <= 1'b0;
      cmd_rd_wr_n_q <= 1'b0;
      cmd_addr_q    <= '0;
      cmd_wdata_q   <= '0;
      cmd_timeout_q <= 1'b0;
    end else begin
      cmd_sel_q     <= 1'b0;
      cmd_timeout_q <= 1'b0;
      mib_ack_q     <= 1'b0;
      case (state_q)
        StIdle: begin
          if (i_mib_start && (i_mib_ad[7:4] == P_MIB_MSN)) begin
            cmd_rd_wr_n_q     <= i_mib_rd_wr_n;
            cmd_addr_q[23:16] <= i_mib_ad[7:0];
            if (i_mib_rd_wr_n) begin
              cmd_wdata_q <= '0;
            end
            state_q <= StAddr2;
          end
        end
        StAddr2: begin
          cmd_addr_q[15:0] <= i_mib_ad;
          if (cmd_rd_wr_n_q) begin
            cmd_sel_q  <= 1'b1;
            wait_cnt_q <= '0;
            state_q    <= StCmdWait;
          end else begin
            state_q <= StWdata1;
          end
        end
        StWdata1: begin
          cmd_wdata_q[31:16] <= i_mib_ad;
          state_q            <= StWdata2;
        end
        StWdata2: begin
          cmd_wdata_q[15:0] <= i_mib_ad;
          cmd_sel_q         <= 1'b1;
          wait_cnt_q        <= '0;
          state_q           <= StCmdWait;
        end
        StCmdWait: begin
          if (i_cmd_ack) begin
            mib_ack_q <= 1'b1;
            if (cmd_rd_wr_n_q) begin
              // High half goes out straight away; low half is parked for the next cycle.
              rdata_lo_q  <= i_cmd_rdata[15:0];
              mib_ad_q    <= i_cmd_rdata[31:16];
              mib_ad_oe_q <= 1'b1;
              state_q     <= StRdHi;
            end else begin
              state_q <= StIdle;
            end
          end else if (wait_cnt_q == TimeoutLast) begin
            cmd_timeout_q <= 1'b1;
            state_q       <= StIdle;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        StRdHi: begin
          mib_ad_q    <= rdata_lo_q;
          mib_ad_oe_q <= 1'b1;
          mib_ack_q   <= 1'b1;
          state_q     <= StRdLo;
        end
        StRdLo: begin
          mib_ad_q    <= '0;
          mib_ad_oe_q <= 1'b0;
          state_q     <= StIdle;
        end
        default: begin
          mib_ad_q    <= '0;
          mib_ad_oe_q <= 1'b0;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign o_mib_ad        = mib_ad_q;
  assign o_mib_ad_oe     = mib_ad_oe_q;
  assign o_mib_slave_ack = mib_ack_q;
  assign o_cmd_sel       = cmd_sel_q;
  assign o_cmd_rd_wr_n   = cmd_rd_wr_n_q;
  assign o_cmd_byte_addr = cmd_addr_q;
  assign o_cmd_wdata     = cmd_wdata_q;
  assign o_cmd_timeout   = cmd_timeout_q;

endmodule

// File: tb/tb_mib_cmd_slave.sv
// Directed bench for mib_cmd_slave: write, read, MSN mismatch, cmd timeout, spurious
// start/ack and mid-read reset, each step checked against hand-computed values.
module tb_mib_cmd_slave;

  logic        clk = 1'b0;
  logic        srst;
  logic        mib_start;
  logic        mib_rd_wr_n;
  logic [15:0] mib_ad_in;
  logic [15:0] mib_ad_out;
  logic        mib_ad_oe;
  logic        mib_ack;
  logic        cmd_sel;
  logic        cmd_rd_wr_n;
  logic [23:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        cmd_ack;
  logic [31:0] cmd_rdata;
  logic        cmd_timeout;

  int n_pass  = 0;
  int n_total = 0;
  logic seen;

  always #5 clk = ~clk;

  mib_cmd_slave #(
    .P_MIB_MSN             (4'h0),
    .P_CMD_ACK_TIMEOUT_CLKS(16)
  ) dut (
    .i_sysclk       (clk),
    .i_srst         (srst),
    .i_mib_start    (mib_start),
    .i_mib_rd_wr_n  (mib_rd_wr_n),
    .i_mib_ad       (mib_ad_in),
    .o_mib_ad       (mib_ad_out),
    .o_mib_ad_oe    (mib_ad_oe),
    .o_mib_slave_ack(mib_ack),
    .o_cmd_sel      (cmd_sel),
    .o_cmd_rd_wr_n  (cmd_rd_wr_n),
    .o_cmd_byte_addr(cmd_addr),
    .o_cmd_wdata    (cmd_wdata),
    .i_cmd_ack      (cmd_ack),
    .i_cmd_rdata    (cmd_rdata),
    .o_cmd_timeout  (cmd_timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Drives A1/A2; returns in cycle t+2.
  task automatic phase_a(input logic rd, input logic [23:0] a);
    mib_start   = 1'b1;
    mib_rd_wr_n = rd;
    mib_ad_in   = {8'h00, a[23:16]};
    tick();
    mib_start = 1'b0;
    mib_ad_in = a[15:0];
    tick();
    mib_ad_in = 16'h0000;
  endtask

  // Drives W1/W2; returns in cycle t+4.
  task automatic phase_w(input logic [31:0] d);
    mib_ad_in = d[31:16];
    tick();
    mib_ad_in = d[15:0];
    tick();
    mib_ad_in = 16'h0000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    srst        = 1'b1;
    mib_start   = 1'b0;
    mib_rd_wr_n = 1'b0;
    mib_ad_in   = 16'h0000;
    cmd_ack     = 1'b0;
    cmd_rdata   = 32'h0;
    tick();
    tick();
    chk("rst_sel", {31'b0, cmd_sel}, 32'h0);
    chk("rst_oe_ack", {30'b0, mib_ad_oe, mib_ack}, 32'h0);
    chk("rst_ad", {16'h0, mib_ad_out}, 32'h0);
    chk("rst_addr", {8'h0, cmd_addr}, 32'h0);
    chk("rst_wdata_to", cmd_wdata | {31'b0, cmd_timeout} | {31'b0, cmd_rd_wr_n}, 32'h0);
    srst = 1'b0;
    tick();

    // Write 0x000004 <- 0x01010202, cmd ack 3 clocks after sel.
    phase_a(1'b0, 24'h000004);
    chk("wr_sel_early", {31'b0, cmd_sel}, 32'h0);
    phase_w(32'h01010202);
    chk("wr_sel", {31'b0, cmd_sel}, 32'h1);
    chk("wr_dir", {31'b0, cmd_rd_wr_n}, 32'h0);
    chk("wr_addr", {8'h0, cmd_addr}, 32'h000004);
    chk("wr_wdata", cmd_wdata, 32'h01010202);
    tick();
    chk("wr_sel_one", {31'b0, cmd_sel}, 32'h0);
    chk("wr_no_ack_yet", {31'b0, mib_ack}, 32'h0);
    tick();
    tick();
    cmd_ack = 1'b1;
    chk("wr_addr_hold", {8'h0, cmd_addr}, 32'h000004);
    tick();
    cmd_ack = 1'b0;
    chk("wr_mib_ack", {30'b0, mib_ad_oe, mib_ack}, 32'h1);
    tick();
    chk("wr_mib_ack_one", {31'b0, mib_ack}, 32'h0);

    // Read 0x000008 -> 0xDEADBEEF, ack the cycle after sel.
    phase_a(1'b1, 24'h000008);
    chk("rd_sel", {31'b0, cmd_sel}, 32'h1);
    chk("rd_dir", {31'b0, cmd_rd_wr_n}, 32'h1);
    chk("rd_addr", {8'h0, cmd_addr}, 32'h000008);
    tick();
    cmd_ack   = 1'b1;
    cmd_rdata = 32'hDEADBEEF;
    tick();
    cmd_ack   = 1'b0;
    cmd_rdata = 32'h0;
    chk("rd_hi", {14'b0, mib_ad_oe, mib_ack, mib_ad_out}, {16'h0003, 16'hDEAD});
    tick();
    chk("rd_lo", {14'b0, mib_ad_oe, mib_ack, mib_ad_out}, {16'h0003, 16'hBEEF});
    tick();
    chk("rd_end", {14'b0, mib_ad_oe, mib_ack, mib_ad_out}, 32'h0);

    // MSN mismatch: read 0x300000 must be ignored entirely.
    phase_a(1'b1, 24'h300000);
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      seen = seen | cmd_sel | mib_ad_oe | mib_ack;
      tick();
    end
    chk("msn_ignored", {31'b0, seen}, 32'h0);
    phase_a(1'b1, 24'h00000C);
    chk("msn_next_sel", {31'b0, cmd_sel}, 32'h1);
    chk("msn_next_addr", {8'h0, cmd_addr}, 32'h00000C);
    cmd_ack   = 1'b1;
    cmd_rdata = 32'h11223344;
    tick();
    cmd_ack = 1'b0;
    chk("msn_next_hi", {14'b0, mib_ad_oe, mib_ack, mib_ad_out}, {16'h0003, 16'h1122});
    tick();
    chk("msn_next_lo", {14'b0, mib_ad_oe, mib_ack, mib_ad_out}, {16'h0003, 16'h3344});
    tick();

    // Write with no cmd ack: timeout 16 clocks after sel, then back-to-back read.
    phase_a(1'b0, 24'h000020);
    phase_w(32'hCAFEF00D);
    chk("to_sel", {31'b0, cmd_sel}, 32'h1);
    seen = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k < 16) seen = seen | cmd_timeout | mib_ack;
    end
    chk("to_early", {31'b0, seen}, 32'h0);
    chk("to_pulse", {30'b0, cmd_timeout, mib_ack}, 32'h2);
    phase_a(1'b1, 24'h000024);
    chk("to_rd_sel", {31'b0, cmd_sel}, 32'h1);
    chk("to_rd_addr", {8'h0, cmd_addr}, 32'h000024);
    tick();
    tick();
    cmd_ack   = 1'b1;
    cmd_rdata = 32'hA5A55A5A;
    tick();
    cmd_ack = 1'b0;
    chk("to_rd_hi", {14'b0, mib_ad_oe, mib_ack, mib_ad_out}, {16'h0003, 16'hA5A5});
    tick();
    chk("to_rd_lo", {14'b0, mib_ad_oe, mib_ack, mib_ad_out}, {16'h0003, 16'h5A5A});
    tick();

    // Stray cmd ack in IDLE, then spurious start during CMD_WAIT.
    cmd_ack   = 1'b1;
    cmd_rdata = 32'hFFFFFFFF;
    tick();
    cmd_ack = 1'b0;
    chk("stray_ack", {14'b0, mib_ad_oe, mib_ack, mib_ad_out}, 32'h0);
    phase_a(1'b0, 24'h000014);
    phase_w(32'h55667788);
    chk("sp_sel", {31'b0, cmd_sel}, 32'h1);
    mib_start   = 1'b1;
    mib_rd_wr_n = 1'b1;
    mib_ad_in   = 16'h0001;
    tick();
    mib_start = 1'b0;
    mib_ad_in = 16'hFFFF;
    tick();
    mib_ad_in = 16'h0000;
    chk("sp_no_sel", {31'b0, cmd_sel}, 32'h0);
    chk("sp_dir", {31'b0, cmd_rd_wr_n}, 32'h0);
    chk("sp_addr", {8'h0, cmd_addr}, 32'h000014);
    chk("sp_wdata", cmd_wdata, 32'h55667788);
    cmd_ack = 1'b1;
    tick();
    cmd_ack = 1'b0;
    chk("sp_mib_ack", {30'b0, mib_ad_oe, mib_ack}, 32'h1);
    tick();

    // Reset during RD_HI, then a normal write.
    phase_a(1'b1, 24'h000018);
    cmd_ack   = 1'b1;
    cmd_rdata = 32'h0BADF00D;
    tick();
    cmd_ack = 1'b0;
    chk("rst_rd_hi", {14'b0, mib_ad_oe, mib_ack, mib_ad_out}, {16'h0003, 16'h0BAD});
    srst = 1'b1;
    tick();
    srst = 1'b0;
    chk("rst_mid_bus", {14'b0, mib_ad_oe, mib_ack, mib_ad_out}, 32'h0);
    tick();
    chk("rst_mid_quiet", {14'b0, mib_ad_oe, mib_ack, mib_ad_out}, 32'h0);
    phase_a(1'b0, 24'h000010);
    phase_w(32'h12345678);
    chk("post_sel", {31'b0, cmd_sel}, 32'h1);
    chk("post_addr", {8'h0, cmd_addr}, 32'h000010);
    chk("post_wdata", cmd_wdata, 32'h12345678);
    tick();
    cmd_ack = 1'b1;
    tick();
    cmd_ack = 1'b0;
    chk("post_ack", {30'b0, mib_ad_oe, mib_ack}, 32'h1);
    tick();
    chk("post_idle", {30'b0, mib_ad_oe, mib_ack}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
